// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, widths.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package lsu_pkg;

    localparam int XLEN   = 32;
    localparam int NBYTES = 4;

    // RV32I load/store width codes (funct3)
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2,
        DONE  = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering for one access: legality, byte enables, store replication, load extraction.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
// Ports: is_store/funct3/byte_off describe the access; wdata is raw store data;
//        mem_rdata is the raw bus word; legal/be/store_data/load_data are the results.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [1:0]        byte_off,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              legal,
    output logic [NBYTES-1:0] be,
    output logic [XLEN-1:0]   store_data,
    output logic [XLEN-1:0]   load_data
);

    logic            f3_ok;
    logic            aligned;
    logic [XLEN-1:0] lane;

    always_comb begin
        f3_ok      = 1'b0;
        aligned    = 1'b0;
        be         = 4'b1111;
        store_data = wdata;
        load_data  = '0;
        lane       = mem_rdata >> {byte_off, 3'b000};

        if (is_store) begin
            f3_ok = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
        end else begin
            f3_ok = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                    (funct3 == LBU) || (funct3 == LHU);
        end

        // funct3[1:0] encodes access size for both loads and stores
        case (funct3[1:0])
            2'b00: begin
                aligned    = 1'b1;
                be         = 4'b0001 << byte_off;
                store_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                aligned    = ~byte_off[0];
                be         = byte_off[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata[15:0]}};
            end
            2'b10: begin
                aligned    = (byte_off == 2'b00);
                be         = 4'b1111;
                store_data = wdata;
            end
            default: begin
                aligned    = 1'b0;
                be         = 4'b1111;
                store_data = wdata;
            end
        endcase

        legal = f3_ok && aligned;

        case (funct3)
            LB:      load_data = {{24{lane[7]}}, lane[7:0]};
            LH:      load_data = {{16{lane[15]}}, lane[15:0]};
            LBU:     load_data = {24'd0, lane[7:0]};
            LHU:     load_data = {16'd0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one core request at a time, legality check, req/ack bus with watchdog.
// Latency: done 3 cycles after start with a first-cycle ack (2 on a fault), +1 per wait cycle.
// Backpressure: start ignored while busy; bus stalls via mem_ack, aborted after TIMEOUT_CYCLES.
// Ports: core side start/is_store/funct3/addr/wdata in, busy/done/rdata/misaligned/bus_err out;
//        bus side mem_req/mem_we/mem_addr/mem_be/mem_wdata out, mem_ack/mem_rdata in.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   rdata,
    output logic              misaligned,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [NBYTES-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam logic [8:0] TMO = 9'(TIMEOUT_CYCLES);

    lsu_state_t      state_q, state_d;
    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [7:0]      cnt_q, cnt_d;
    logic [8:0]      cnt_inc;
    logic            timeout;

    logic              legal;
    logic [NBYTES-1:0] al_be;
    logic [XLEN-1:0]   al_store;
    logic [XLEN-1:0]   al_load;

    logic              busy_d, done_d, mis_d, berr_d, req_d, we_d;
    logic [XLEN-1:0]   rdata_d, maddr_d, mwdata_d;
    logic [NBYTES-1:0] mbe_d;

    lsu_lane_align u_align (
        .is_store   (is_store_q),
        .funct3     (funct3_q),
        .byte_off   (addr_q[1:0]),
        .wdata      (wdata_q),
        .mem_rdata  (mem_rdata),
        .legal      (legal),
        .be         (al_be),
        .store_data (al_store),
        .load_data  (al_load)
    );

    // The current REQ cycle is the cnt_inc-th one; reaching the limit aborts unless acked.
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;
    assign timeout = (cnt_inc >= TMO);

    // State register, request latch and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            rdata      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            if (state_q == IDLE && start) begin
                is_store_q <= is_store;
                funct3_q   <= funct3;
                addr_q     <= addr;
                wdata_q    <= wdata;
            end
            busy       <= busy_d;
            done       <= done_d;
            misaligned <= mis_d;
            bus_err    <= berr_d;
            rdata      <= rdata_d;
            mem_req    <= req_d;
            mem_we     <= we_d;
            mem_addr   <= maddr_d;
            mem_be     <= mbe_d;
            mem_wdata  <= mwdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK:   state_d = legal ? REQ : DONE;
            REQ:     if (mem_ack || timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        mis_d    = (state_q == CHECK) && !legal;
        berr_d   = (state_q == REQ) && !mem_ack && timeout;
        req_d    = (state_d == REQ);
        we_d     = (state_d == REQ) && is_store_q;
        cnt_d    = (state_q == REQ) ? cnt_inc[7:0] : 8'd0;
        rdata_d  = rdata;
        maddr_d  = mem_addr;
        mbe_d    = mem_be;
        mwdata_d = mem_wdata;

        // Bus fields are loaded once on entry to REQ and then held for the whole request
        if (state_q == CHECK && legal) begin
            maddr_d  = {addr_q[XLEN-1:2], 2'b00};
            mbe_d    = al_be;
            mwdata_d = al_store;
        end

        if (state_q == REQ) begin
            if (mem_ack) begin
                if (!is_store_q) rdata_d = al_load;
            end else if (timeout) begin
                rdata_d = '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (watchdog limit set to 4 cycles).
// Latency: n/a.
// Backpressure: bench models a memory with programmable ack delay.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, misaligned, bus_err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          ack_n;     // ack in this REQ cycle, 0 = never
        logic [31:0] rd;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_addr;
        logic [31:0] e_rdata;
        int          e_done;    // cycle of done, start sampled at edge 0
    } vec_t;

    vec_t exp_q[$];

    // Observations from the last operation
    int          obs_done_cyc, obs_done_cnt, obs_req_cnt, obs_busy1;
    logic        obs_unstable, obs_we, obs_mis, obs_berr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata, obs_addr, obs_rdata;

    // Drives one request and watches the DUT; values are sampled 1 time unit after each edge.
    task automatic run_op(input vec_t v, input int pulse_at);
        @(posedge clk); #1;
        start = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.a; wdata = v.wd;
        @(posedge clk); #1;
        start = 1'b0;
        obs_done_cyc = -1; obs_done_cnt = 0; obs_req_cnt = 0; obs_busy1 = int'(busy);
        obs_unstable = 1'b0; obs_we = 1'b0; obs_be = '0; obs_wdata = '0; obs_addr = '0;
        obs_rdata = '0; obs_mis = 1'b0; obs_berr = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (c == pulse_at) begin
                start = 1'b1; addr = 32'h200; funct3 = 3'b000;
            end else begin
                start = 1'b0;
            end
            if (mem_req) begin
                obs_req_cnt++;
                if (obs_req_cnt == 1) begin
                    obs_be = mem_be; obs_wdata = mem_wdata; obs_addr = mem_addr; obs_we = mem_we;
                end else if (mem_be !== obs_be || mem_wdata !== obs_wdata ||
                             mem_addr !== obs_addr || mem_we !== obs_we) begin
                    obs_unstable = 1'b1;
                end
                mem_ack = (obs_req_cnt == v.ack_n);
                mem_rdata = v.rd;
            end else begin
                mem_ack = 1'b0;
            end
            if (done) begin
                obs_done_cnt++;
                obs_done_cyc = c;
                obs_rdata = rdata; obs_mis = misaligned; obs_berr = bus_err;
            end
            if (obs_done_cyc >= 0 && c >= obs_done_cyc + 3) break;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, misaligned, bus_err, mem_req, mem_we} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags got %b want 000000",
                              {busy, done, misaligned, bus_err, mem_req, mem_we});
        end
        n_vec++;
        if ({rdata, mem_addr, mem_wdata, mem_be} !== 100'd0) begin
            n_err++; $display("FAIL reset_buses rdata=%h addr=%h wdata=%h be=%b want zeros",
                              rdata, mem_addr, mem_wdata, mem_be);
        end
        reset = 1'b0;
    endtask

    task automatic test_stores();
        vec_t v, e;
        vec_t tbl[3];
        tbl[0] = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 32'h0, 4'b1111, 32'hDEADBEEF, 32'h100, 32'h0, 3};
        tbl[1] = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 1, 32'h0, 4'b1000, 32'hA5A5A5A5, 32'h100, 32'h0, 3};
        tbl[2] = '{1'b1, 3'b001, 32'h106, 32'h1234ABCD, 2, 32'h0, 4'b1100, 32'hABCDABCD, 32'h104, 32'h0, 4};
        for (int i = 0; i < 3; i++) begin
            v = tbl[i];
            exp_q.push_back(v);
            run_op(v, -1);
            e = exp_q.pop_front();
            n_vec++;
            if (obs_be !== e.e_be || obs_wdata !== e.e_wdata || obs_addr !== e.e_addr || obs_we !== 1'b1) begin
                n_err++; $display("FAIL store%0d_bus got be=%b wd=%h a=%h we=%b want be=%b wd=%h a=%h we=1",
                                  i, obs_be, obs_wdata, obs_addr, obs_we, e.e_be, e.e_wdata, e.e_addr);
            end
            n_vec++;
            if (obs_done_cyc !== e.e_done || obs_done_cnt !== 1 || obs_busy1 !== 1) begin
                n_err++; $display("FAIL store%0d_timing got done_cyc=%0d cnt=%0d busy1=%0d want %0d/1/1",
                                  i, obs_done_cyc, obs_done_cnt, obs_busy1, e.e_done);
            end
        end
    endtask

    task automatic test_loads();
        vec_t v, e;
        vec_t tbl[6];
        tbl[0] = '{1'b0, 3'b000, 32'h0, 32'h0, 1, 32'h80F07F81, 4'b0001, 32'h0, 32'h0, 32'hFFFFFF81, 3};
        tbl[1] = '{1'b0, 3'b100, 32'h0, 32'h0, 1, 32'h80F07F81, 4'b0001, 32'h0, 32'h0, 32'h00000081, 3};
        tbl[2] = '{1'b0, 3'b001, 32'h2, 32'h0, 1, 32'h80F07F81, 4'b1100, 32'h0, 32'h0, 32'hFFFF80F0, 3};
        tbl[3] = '{1'b0, 3'b101, 32'h2, 32'h0, 1, 32'h80F07F81, 4'b1100, 32'h0, 32'h0, 32'h000080F0, 3};
        tbl[4] = '{1'b0, 3'b000, 32'h1, 32'h0, 2, 32'h80F07F81, 4'b0010, 32'h0, 32'h0, 32'h0000007F, 4};
        tbl[5] = '{1'b0, 3'b010, 32'h44, 32'h0, 1, 32'h80F07F81, 4'b1111, 32'h0, 32'h44, 32'h80F07F81, 3};
        for (int i = 0; i < 6; i++) begin
            v = tbl[i];
            exp_q.push_back(v);
            run_op(v, -1);
            e = exp_q.pop_front();
            n_vec++;
            if (obs_rdata !== e.e_rdata || obs_mis !== 1'b0 || obs_berr !== 1'b0) begin
                n_err++; $display("FAIL load%0d_data got %h mis=%b berr=%b want %h mis=0 berr=0",
                                  i, obs_rdata, obs_mis, obs_berr, e.e_rdata);
            end
            n_vec++;
            if (obs_be !== e.e_be || obs_addr !== e.e_addr || obs_we !== 1'b0 || obs_done_cyc !== e.e_done) begin
                n_err++; $display("FAIL load%0d_bus got be=%b a=%h we=%b done_cyc=%0d want be=%b a=%h we=0 done_cyc=%0d",
                                  i, obs_be, obs_addr, obs_we, obs_done_cyc, e.e_be, e.e_addr, e.e_done);
            end
        end
    endtask

    task automatic test_faults();
        vec_t v, e;
        vec_t tbl[3];
        tbl[0] = '{1'b0, 3'b010, 32'h102, 32'h0, 1, 32'h0, 4'b0, 32'h0, 32'h0, 32'h0, 2};
        tbl[1] = '{1'b1, 3'b011, 32'h100, 32'h55, 1, 32'h0, 4'b0, 32'h0, 32'h0, 32'h0, 2};
        tbl[2] = '{1'b0, 3'b001, 32'h101, 32'h0, 1, 32'h0, 4'b0, 32'h0, 32'h0, 32'h0, 2};
        for (int i = 0; i < 3; i++) begin
            v = tbl[i];
            exp_q.push_back(v);
            run_op(v, -1);
            e = exp_q.pop_front();
            n_vec++;
            if (obs_mis !== 1'b1 || obs_berr !== 1'b0 || obs_done_cyc !== e.e_done || obs_done_cnt !== 1) begin
                n_err++; $display("FAIL fault%0d got mis=%b berr=%b done_cyc=%0d cnt=%0d want 1/0/%0d/1",
                                  i, obs_mis, obs_berr, obs_done_cyc, obs_done_cnt, e.e_done);
            end
            n_vec++;
            if (obs_req_cnt !== 0) begin
                n_err++; $display("FAIL fault%0d_noreq got req_cycles=%0d want 0", i, obs_req_cnt);
            end
        end
    endtask

    task automatic test_timeout();
        vec_t v, e;
        v = '{1'b0, 3'b010, 32'h8, 32'h0, 0, 32'h12345678, 4'b1111, 32'h0, 32'h8, 32'h0, 6};
        exp_q.push_back(v);
        run_op(v, -1);
        e = exp_q.pop_front();
        n_vec++;
        if (obs_req_cnt !== 4 || obs_done_cyc !== e.e_done) begin
            n_err++; $display("FAIL timeout_len got req_cycles=%0d done_cyc=%0d want 4/%0d",
                              obs_req_cnt, obs_done_cyc, e.e_done);
        end
        n_vec++;
        if (obs_berr !== 1'b1 || obs_mis !== 1'b0 || obs_rdata !== e.e_rdata) begin
            n_err++; $display("FAIL timeout_resp got berr=%b mis=%b rdata=%h want 1/0/%h",
                              obs_berr, obs_mis, obs_rdata, e.e_rdata);
        end
    endtask

    // Ack in the last counted cycle, start pulsed during REQ, then reset in REQ of a second request.
    task automatic test_back_to_back();
        vec_t v, e;
        int   extra;
        v = '{1'b0, 3'b101, 32'h6, 32'h0, 4, 32'hC3C3_8001, 4'b1100, 32'h0, 32'h4, 32'h0000C3C3, 6};
        exp_q.push_back(v);
        run_op(v, 3);
        e = exp_q.pop_front();
        n_vec++;
        if (obs_done_cnt !== 1 || obs_done_cyc !== e.e_done || obs_berr !== 1'b0) begin
            n_err++; $display("FAIL late_ack got cnt=%0d done_cyc=%0d berr=%b want 1/%0d/0",
                              obs_done_cnt, obs_done_cyc, obs_berr, e.e_done);
        end
        n_vec++;
        if (obs_rdata !== e.e_rdata || obs_unstable !== 1'b0 || obs_addr !== e.e_addr) begin
            n_err++; $display("FAIL late_ack_data got rdata=%h unstable=%b addr=%h want %h/0/%h",
                              obs_rdata, obs_unstable, obs_addr, e.e_rdata, e.e_addr);
        end

        @(posedge clk); #1;
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h40; wdata = 32'h11223344;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (mem_req !== 1'b1) begin
            n_err++; $display("FAIL rst_prereq got mem_req=%b want 1", mem_req);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_vec++;
        if ({busy, done, misaligned, bus_err, mem_req, mem_we} !== 6'b0 ||
            {rdata, mem_addr, mem_wdata, mem_be} !== 100'd0) begin
            n_err++; $display("FAIL rst_mid got flags=%b rdata=%h addr=%h wd=%h be=%b want zeros",
                              {busy, done, misaligned, bus_err, mem_req, mem_we},
                              rdata, mem_addr, mem_wdata, mem_be);
        end
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            mem_ack = 1'b1;
            if (done) extra++;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        n_vec++;
        if (extra !== 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rst_nodone got done_pulses=%0d busy=%b want 0/0", extra, busy);
        end
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_faults();
        test_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, vectors=%0d", n_vec);
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the single-cycle core's datapath and a word-wide data memory bus. It accepts one load or store request from the core at a time, checks alignment and funct3 legality, and drives a req/ack memory handshake with byte enables. It returns sign- or zero-extended load data with a completion pulse, and includes a watchdog timeout for a memory that never acknowledges. It decodes and executes the memory accesses that the controller's `MemWrite`/`ResultSrc` path requests.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum REQ cycles without `mem_ack` before abort; legal range 1..255.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request strobe from the core; sampled only in IDLE.
- `is_store` input 1: 1 = store, 0 = load.
- `funct3` input 3: RV32I width/sign code (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010).
- `addr` input 32: byte address (rs1 + imm).
- `wdata` input 32: store data (rs2).
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: one-cycle completion pulse.
- `rdata` output 32: formatted load result; valid with `done`, held until the next completed load.
- `misaligned` output 1: valid with `done`; alignment or illegal-funct3 fault.
- `bus_err` output 1: valid with `done`; timeout fault.
- `mem_req` output 1: bus request.
- `mem_we` output 1: bus write enable.
- `mem_addr` output 32: word address, `{addr[31:2],2'b00}`.
- `mem_be` output 4: byte enables.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_ack` input 1: bus acknowledge; read data is valid in the same cycle.
- `mem_rdata` input 32: bus read data.

## Operation
- States: IDLE, CHECK, REQ, DONE.
- IDLE, `start`=1: latch `is_store`, `funct3`, `addr`, `wdata`, then go to CHECK. If `start`=0, stay in IDLE.
- CHECK, legality:
  - Loads: funct3 must be in {000, 001, 010, 100, 101}.
  - Stores: funct3 must be in {000, 001, 010}.
  - Alignment: half-word access requires `addr[0]`=0; word access requires `addr[1:0]`=00.
  - Fault: go to DONE with `misaligned`=1. No bus activity.
  - OK: go to REQ.
- REQ:
  - `mem_req`=1. `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` stay stable for the whole REQ interval.
  - Wait counter increments every REQ cycle.
  - On `mem_ack`=1, go to DONE. For a load, capture the formatted `mem_rdata` into `rdata`.
  - If the counter reaches `TIMEOUT_CYCLES` with no ack, go to DONE with `bus_err`=1 and `rdata`=0.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Store lanes:
  - SB: `mem_wdata`={4{wdata[7:0]}}, `mem_be`=4'b0001<<addr[1:0].
  - SH: `mem_wdata`={2{wdata[15:0]}}, `mem_be`=addr[1]?1100:0011.
  - SW: `mem_wdata`=wdata, `mem_be`=1111.
- Loads: `mem_be` follows the same byte-enable rule. Selected lane = `mem_rdata >> (8*addr[1:0])`. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- `start` outside IDLE (including DONE) is ignored, not queued.
- `mem_ack` outside REQ is ignored.
- `misaligned` and `bus_err` are never both 1.

## Timing
- All outputs are registered.
- Reset values: `busy`, `done`, `misaligned`, `bus_err`, `mem_req`, `mem_we` = 0; `mem_be`=0000; `rdata`, `mem_addr`, `mem_wdata` = 0; state=IDLE; counter=0.
- Cycle numbering: `start` sampled at edge 0, CHECK in cycle 1, `mem_req` high from cycle 2.
  - Ack in the first REQ cycle (cycle 2): `done` in cycle 3.
  - Ack in the n-th REQ cycle: `done` in cycle n+2.
- Fault path: `done`/`misaligned` in cycle 2.
- Timeout: `mem_req` is high for exactly `TIMEOUT_CYCLES` cycles, then `done`/`bus_err` follows.
- Ack on the final counted cycle wins over timeout.
- Reset mid-operation: the next edge forces IDLE and reset values. `mem_req` drops in that cycle, and no `done` is produced for the aborted request.

## Structure
- Package `lsu_pkg`:
  - funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW.
  - State enum {IDLE, CHECK, REQ, DONE}.
  - Width constants `XLEN`=32, `NBYTES`=4.
- Sub-module `lsu_lane_align` (combinational): store lane replication, byte-enable generation, load extraction and sign/zero extension, legality check. The FSM and counter live in `load_store_unit`.

## Test plan
- SW: addr 0x100, wdata 0xDEADBEEF, ack in first REQ cycle -> `mem_addr` 0x100, `mem_be` 1111, `mem_wdata` 0xDEADBEEF, `done` in cycle 3.
- SB: addr 0x103, wdata 0x000000A5 -> `mem_be` 1000, `mem_wdata` 0xA5A5A5A5.
- Loads with `mem_rdata` 0x80F0_7F81:
  - LB addr 0x0 -> `rdata` 0xFFFFFF81.
  - LBU addr 0x0 -> `rdata` 0x00000081.
  - LH addr 0x2 -> `rdata` 0xFFFF80F0.
  - LHU addr 0x2 -> `rdata` 0x000080F0.
- Faults:
  - LW addr 0x102 -> `done` + `misaligned` in cycle 2, `mem_req` never high.
  - Store with funct3 011 -> same fault response.
- `TIMEOUT_CYCLES`=4, no ack -> `mem_req` high 4 cycles, then `done`+`bus_err`, `rdata`=0.
- Ack held off 3 cycles, `start` pulsed during REQ, then `reset` asserted in REQ on a second request -> exactly one `done` for the first request; after reset, outputs at reset values and no `done`.
